// File: rtl/reset_seq_gen.sv
// Sequenced reset-request generator for the BNN datapath sub-domains (POR, soft reset, watchdog).
// Define RESET_SEQ_GEN_WDT_EN to build the watchdog; without it wdt_en/wdt_kick are ignored.
module reset_seq_gen #(
   parameter int PULSE_CYCLES = 16,
   parameter int NUM_STAGES   = 3,
   parameter int STAGE_GAP    = 4,
   parameter int WDT_CYCLES   = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  soft_rst_req,
   input  logic                  wdt_en,
   input  logic                  wdt_kick,
   output logic [NUM_STAGES-1:0] rst_stage,
   output logic                  rst_any,
   output logic                  seq_busy,
   output logic [1:0]            rst_cause,
   output logic                  seq_done,
   output logic [1:0]            dbg_state
);

   // Handshake note: there is no valid/ready pair here; soft_rst_req and wdt_kick are
   // single-cycle strobes sampled on every rising clk edge, never held or acknowledged.

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int CNT_MAX = (PULSE_CYCLES > STAGE_GAP) ? PULSE_CYCLES : STAGE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]      PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]      GAP_LAST   = CNT_W'(STAGE_GAP - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ONES   = '1;

   localparam logic [1:0] CAUSE_POR  = 2'd0;
   localparam logic [1:0] CAUSE_SOFT = 2'd1;
   localparam logic [1:0] CAUSE_WDT  = 2'd2;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_STAGES-1:0] stage_d;
   logic [1:0]            cause_d;
   logic                  done_d;
   logic                  busy_d;
   logic                  wdt_expire;

`ifdef RESET_SEQ_GEN_WDT_EN
   localparam int WDT_W = $clog2(WDT_CYCLES);

   logic [WDT_W-1:0] wdt_cnt_q;

   // A kick in the expiry cycle wins, so it is excluded from the expiry term.
   always_comb begin
      wdt_expire = (state_q == IDLE) && wdt_en && !wdt_kick &&
                   (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdt_cnt_q <= '0;
      end else if ((state_q != IDLE) || !wdt_en || wdt_kick || wdt_expire) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_q + 1'b1;
      end
   end
`else
   logic wdt_unused;

   assign wdt_unused = wdt_en ^ wdt_kick;
   assign wdt_expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = rst_stage;
      cause_d = rst_cause;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d   = '0;
            stage_d = '0;
            if (soft_rst_req) begin
               state_d = ASSERT;
               stage_d = ALL_ONES;
               cause_d = CAUSE_SOFT;
            end else if (wdt_expire) begin
               state_d = ASSERT;
               stage_d = ALL_ONES;
               cause_d = CAUSE_WDT;
            end
         end

         ASSERT: begin
            stage_d = ALL_ONES;
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               stage_d = ALL_ONES << 1;
               if (stage_d == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RELEASE: begin
            // Shifting in a zero keeps the vector thermometer-shaped.
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               stage_d = rst_stage << 1;
               if (stage_d == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            stage_d = '0;
         end
      endcase

      // A soft request mid-sequence restarts it and swallows any pending done pulse.
      if ((state_q != IDLE) && soft_rst_req) begin
         state_d = ASSERT;
         cnt_d   = '0;
         stage_d = ALL_ONES;
         cause_d = CAUSE_SOFT;
         done_d  = 1'b0;
      end

      busy_d = (state_d != IDLE) || done_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ASSERT;
         cnt_q     <= '0;
         rst_stage <= ALL_ONES;
         rst_any   <= 1'b1;
         seq_busy  <= 1'b1;
         rst_cause <= CAUSE_POR;
         seq_done  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rst_stage <= stage_d;
         rst_any   <= |stage_d;
         seq_busy  <= busy_d;
         rst_cause <= cause_d;
         seq_done  <= done_d;
      end
   end

   assign dbg_state = state_q;

   a_thermometer : assert property (@(posedge clk) disable iff (reset)
      ((rst_stage << 1) & ~rst_stage) == '0);

   a_done_clear : assert property (@(posedge clk) disable iff (reset)
      seq_done |-> (rst_stage == '0));

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed self-checking bench for reset_seq_gen (default build and RESET_SEQ_GEN_WDT_EN build).
module tb_reset_seq_gen;

   localparam int PULSE  = 16;
   localparam int NSTG   = 3;
   localparam int GAP    = 4;
   localparam int WDT    = 32;
   localparam int LAST_C = 24;
   localparam int REL_C [NSTG] = '{16, 20, 24};

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            soft_rst_req = 1'b0;
   logic            wdt_en = 1'b0;
   logic            wdt_kick = 1'b0;
   logic [NSTG-1:0] rst_stage;
   logic            rst_any;
   logic            seq_busy;
   logic [1:0]      rst_cause;
   logic            seq_done;
   logic [1:0]      dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   reset_seq_gen #(
      .PULSE_CYCLES (PULSE),
      .NUM_STAGES   (NSTG),
      .STAGE_GAP    (GAP),
      .WDT_CYCLES   (WDT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .soft_rst_req (soft_rst_req),
      .wdt_en       (wdt_en),
      .wdt_kick     (wdt_kick),
      .rst_stage    (rst_stage),
      .rst_any      (rst_any),
      .seq_busy     (seq_busy),
      .rst_cause    (rst_cause),
      .seq_done     (seq_done),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no end of test, expected end within 2ms");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NSTG-1:0] exp_stage(input int c);
      logic [NSTG-1:0] v;
      v = '1;
      for (int k = 0; k < NSTG; k++) begin
         if (c >= REL_C[k]) v[k] = 1'b0;
      end
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_soft();
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
   endtask

   // Current sample is cycle 0 of a sequence; check cycles 0..last_c.
   task automatic run_seq(input logic [1:0] cause, input int last_c);
      logic [NSTG-1:0] es;
      for (int c = 0; c <= last_c; c++) begin
         if (c != 0) tick();
         es = exp_stage(c);
         check($sformatf("rst_stage c%0d", c), 32'(rst_stage), 32'(es));
         check($sformatf("rst_any c%0d", c), 32'(rst_any), 32'(|es));
         check($sformatf("seq_done c%0d", c), 32'(seq_done), 32'(c == LAST_C));
         check($sformatf("seq_busy c%0d", c), 32'(seq_busy), 32'(c <= LAST_C));
         check($sformatf("rst_cause c%0d", c), 32'(rst_cause), 32'(cause));
      end
   endtask

   task automatic idle_cycles(input string tag, input int n, input logic [1:0] cause);
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s busy i%0d", tag, i), 32'(seq_busy), 32'd0);
         check($sformatf("%s stage i%0d", tag, i), 32'(rst_stage), 32'd0);
         check($sformatf("%s cause i%0d", tag, i), 32'(rst_cause), 32'(cause));
      end
   endtask

   initial begin
      // power-on: three reset edges, then release
      repeat (3) tick();
      check("por stage", 32'(rst_stage), 32'h7);
      check("por any", 32'(rst_any), 32'd1);
      check("por busy", 32'(seq_busy), 32'd1);
      check("por cause", 32'(rst_cause), 32'd0);
      check("por done", 32'(seq_done), 32'd0);
      check("por state", 32'(dbg_state), 32'd1);
      reset = 1'b0;
      run_seq(2'd0, LAST_C + 1);
      check("idle state", 32'(dbg_state), 32'd0);

      // soft reset from IDLE
      tick();
      pulse_soft();
      run_seq(2'd1, LAST_C + 1);

      // soft re-trigger while only stage 2 is still held
      pulse_soft();
      run_seq(2'd1, 22);
      check("retrig pre stage", 32'(rst_stage), 32'h4);
      pulse_soft();
      run_seq(2'd1, LAST_C + 1);

      // system reset mid-RELEASE
      pulse_soft();
      run_seq(2'd1, 21);
      reset = 1'b1;
      tick();
      check("midrst stage", 32'(rst_stage), 32'h7);
      check("midrst cause", 32'(rst_cause), 32'd0);
      check("midrst done", 32'(seq_done), 32'd0);
      check("midrst busy", 32'(seq_busy), 32'd1);
      reset = 1'b0;
      run_seq(2'd0, LAST_C + 1);

`ifdef RESET_SEQ_GEN_WDT_EN
      // expiry with no kicks: 32 idle cycles, then a WDT sequence
      wdt_en = 1'b1;
      idle_cycles("wdt_wait", WDT - 1, 2'd0);
      tick();
      wdt_en = 1'b0;
      run_seq(2'd2, LAST_C + 1);

      // periodic kicks keep it quiet for 200 cycles
      wdt_en = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         wdt_kick = (i % 20 == 0);
         check($sformatf("kick busy i%0d", i), 32'(seq_busy), 32'd0);
      end
      wdt_kick = 1'b0;
      wdt_en = 1'b0;
      tick();

      // soft request in the expiry cycle
      wdt_en = 1'b1;
      idle_cycles("wdt_soft", WDT - 1, 2'd2);
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      wdt_en = 1'b0;
      run_seq(2'd1, LAST_C + 1);

      // kick in the expiry cycle
      wdt_en = 1'b1;
      idle_cycles("wdt_kick", WDT - 1, 2'd1);
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      check("kick_at_expiry busy", 32'(seq_busy), 32'd0);
      check("kick_at_expiry state", 32'(dbg_state), 32'd0);
      idle_cycles("post_kick", WDT - 2, 2'd1);
      wdt_en = 1'b0;
`else
      // watchdog absent: enable and idle well past WDT_CYCLES
      wdt_en = 1'b1;
      idle_cycles("no_wdt", 3 * WDT, 2'd0);
      wdt_kick = 1'b1;
      idle_cycles("no_wdt_kick", 2, 2'd0);
      wdt_kick = 1'b0;
      wdt_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
